fir_sample_streamer: RTL

Transmit-side driver for the FIR input interface. It buffers a block of signed samples, then streams them out as x_out with single-cycle data_valid strobes at a fixed spacing, followed by a flush interval. It replaces bench-side stimulus loops, so that the fir_csm input (data_valid, x_in) can be driven from RTL on-chip or in system simulation.

---
 rtl/fir_stream_pkg.sv | 16 +
 rtl/fir_sample_mem.sv | 30 +++
 rtl/fir_sample_streamer.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/fir_stream_pkg.sv
// Shared types and defaults for the FIR sample streamer.
package fir_stream_pkg;

  localparam int SAMPLE_W         = 16;
  localparam int DEF_GAP          = 1;
  localparam int DEF_FLUSH_CYCLES = 10;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SEND  = 3'd1,
    ST_GAP   = 3'd2,
    ST_FLUSH = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

endpackage

// File: rtl/fir_sample_mem.sv
// Sample buffer: one synchronous write port, one asynchronous read port.
module fir_sample_mem
  import fir_stream_pkg::*;
#(
  parameter int DW    = SAMPLE_W,
  parameter int DEPTH = 100,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [DW-1:0] rdata_o
);

  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  logic [DW-1:0] mem_q [DEPTH];

  // Write port; contents intentionally survive reset
  always_ff @(posedge clk) begin
    if (we_i && ({1'b0, waddr_i} < DEPTH_C)) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = ({1'b0, raddr_i} < DEPTH_C) ? mem_q[raddr_i] : '0;

endmodule

// File: rtl/fir_sample_streamer.sv
// Streams a buffered block of samples to the FIR input as spaced
// single-cycle strobes, then flushes and pulses done.
module fir_sample_streamer
  import fir_stream_pkg::*;
#(
  parameter int DW           = SAMPLE_W,
  parameter int DEPTH        = 100,
  parameter int AW           = $clog2(DEPTH),
  parameter int GAP          = DEF_GAP,
  parameter int FLUSH_CYCLES = DEF_FLUSH_CYCLES
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  input  logic          start,
  input  logic [AW:0]   count,
  input  logic          pause,
  output logic          data_valid,
  output logic [DW-1:0] x_out,
  output logic          busy,
  output logic          done
);

  localparam int GW = $clog2(GAP + 2);
  localparam int FW = $clog2(FLUSH_CYCLES + 2);
  localparam int GAP_LOAD_I   = (GAP > 0) ? GAP - 1 : 0;
  localparam int FLUSH_LOAD_I = (FLUSH_CYCLES > 0) ? FLUSH_CYCLES - 1 : 0;
  localparam logic [GW-1:0] GAP_LOAD   = GW'(GAP_LOAD_I);
  localparam logic [FW-1:0] FLUSH_LOAD = FW'(FLUSH_LOAD_I);
  localparam logic [AW:0]   DEPTH_C    = (AW+1)'(DEPTH);

  state_e        state_q;
  logic [AW:0]   idx_q;
  logic [AW:0]   count_q;
  logic [GW-1:0] gap_cnt_q;
  logic [FW-1:0] flush_cnt_q;
  logic          dv_q;
  logic [DW-1:0] x_q;
  logic          busy_q;
  logic          done_q;

  logic [AW:0]   count_d;
  logic          more_d;
  logic          mem_we_d;
  logic [DW-1:0] rd_data_d;

  // Requested length clamped to the buffer size; remaining-sample flag
  always_comb begin
    count_d = count;
    if (count > DEPTH_C) begin
      count_d = DEPTH_C;
    end else begin
      count_d = count;
    end
    more_d = (idx_q < count_q);
  end

  // Writes are only accepted while no stream is in flight
  assign mem_we_d = wr_en && ((state_q == ST_IDLE) || (state_q == ST_DONE));

  fir_sample_mem #(
    .DW    (DW),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk     (clk),
    .we_i    (mem_we_d),
    .waddr_i (wr_addr),
    .wdata_i (wr_data),
    .raddr_i (idx_q[AW-1:0]),
    .rdata_o (rd_data_d)
  );

  // Streaming FSM with its index, gap and flush counters
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      count_q     <= '0;
      gap_cnt_q   <= '0;
      flush_cnt_q <= '0;
      dv_q        <= 1'b0;
      x_q         <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      dv_q   <= 1'b0;
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          idx_q <= '0;
          if (start) begin
            count_q <= count_d;
            if (count_d != '0) begin
              state_q <= ST_SEND;
              dv_q    <= 1'b1;
              x_q     <= rd_data_d;
              idx_q   <= (AW+1)'(1'b1);
              busy_q  <= 1'b1;
            end else begin
              state_q <= ST_DONE;
              done_q  <= 1'b1;
            end
          end
        end
        ST_SEND: begin
          if (more_d && (GAP == 0) && !pause) begin
            dv_q  <= 1'b1;
            x_q   <= rd_data_d;
            idx_q <= idx_q + (AW+1)'(1'b1);
          end else if (more_d || (GAP != 0)) begin
            // With GAP=0 a paused strobe waits here with the gap already spent
            state_q   <= ST_GAP;
            gap_cnt_q <= GAP_LOAD;
          end else begin
            state_q     <= ST_FLUSH;
            flush_cnt_q <= FLUSH_LOAD;
          end
        end
        ST_GAP: begin
          if (gap_cnt_q == '0) begin
            if (more_d) begin
              if (!pause) begin
                state_q <= ST_SEND;
                dv_q    <= 1'b1;
                x_q     <= rd_data_d;
                idx_q   <= idx_q + (AW+1)'(1'b1);
              end
            end else begin
              state_q     <= ST_FLUSH;
              flush_cnt_q <= FLUSH_LOAD;
            end
          end else begin
            gap_cnt_q <= gap_cnt_q - GW'(1'b1);
          end
        end
        ST_FLUSH: begin
          if (flush_cnt_q == '0) begin
            state_q <= ST_DONE;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
          end else begin
            flush_cnt_q <= flush_cnt_q - FW'(1'b1);
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign data_valid = dv_q;
  assign x_out      = x_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule
